// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode/write-back slice.
// Holds the instruction codes, the special register IDs and the data width
// used by the register-ID decoder and the register file.
package y86_pkg;

    // Architectural data width
    localparam int Y86_DATA_W = 64;

    // Number of architectural registers (IDs 0..14; ID 15 means "none")
    localparam int Y86_NUM_REGS = 15;

    // Instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Special register IDs
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/y86_reg_ids.sv
// Combinational register-ID decoder for the Y86-64 decode stage.
// Ports:
//   icode, ra, rb : instruction fields from fetch
//   cnd           : condition result, gates the cmovXX destination
//   srca, srcb    : read-port register IDs
//   dste, dstm    : write-back destination IDs (E = ALU result, M = memory data)
// Unused / undefined icodes leave every ID at NONE_ID.
module y86_reg_ids
    import y86_pkg::*;
#(
    parameter logic [3:0] RSP_ID  = 4'h4,
    parameter logic [3:0] NONE_ID = 4'hF
) (
    input  logic [3:0] icode,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    input  logic       cnd,
    output logic [3:0] srca,
    output logic [3:0] srcb,
    output logic [3:0] dste,
    output logic [3:0] dstm
);

    // Decode source and destination IDs from the instruction class
    always_comb begin
        srca = NONE_ID;
        srcb = NONE_ID;
        dste = NONE_ID;
        dstm = NONE_ID;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_JXX: begin
                srca = NONE_ID;
            end
            ICODE_RRMOVQ: begin
                srca = ra;
                // cmovXX only commits when the condition holds
                if (cnd) begin
                    dste = rb;
                end else begin
                    dste = NONE_ID;
                end
            end
            ICODE_IRMOVQ: begin
                dste = rb;
            end
            ICODE_RMMOVQ: begin
                srca = ra;
                srcb = rb;
            end
            ICODE_MRMOVQ: begin
                srcb = rb;
                dstm = ra;
            end
            ICODE_OPQ: begin
                srca = ra;
                srcb = rb;
                dste = rb;
            end
            ICODE_CALL: begin
                srcb = RSP_ID;
                dste = RSP_ID;
            end
            ICODE_RET: begin
                srca = RSP_ID;
                srcb = RSP_ID;
                dste = RSP_ID;
            end
            ICODE_PUSHQ: begin
                srca = ra;
                srcb = RSP_ID;
                dste = RSP_ID;
            end
            ICODE_POPQ: begin
                srca = RSP_ID;
                srcb = RSP_ID;
                dste = RSP_ID;
                dstm = ra;
            end
            default: begin
                srca = NONE_ID;
            end
        endcase
    end

endmodule

// File: rtl/y86_regfile_decode.sv
// Y86-64 decode / write-back stage.
// Ports:
//   clk, rst_n        : clock (writes on rising edge), async active-low reset
//   icode, rA, rB, cnd: instruction fields and condition result
//   valE, valM        : ALU result and memory data to commit
//   wb_en             : commit enable, low while the CPU is halted/faulted
//   valA, valB        : combinational read data for srcA / srcB
//   dstE, dstM        : decoded destinations, exported for trace
//   dbg_sel, dbg_val  : debug read port
// Reads have no write-to-read forwarding; ID NONE_ID reads as zero.
module y86_regfile_decode
    import y86_pkg::*;
#(
    parameter int         DATA_W  = 64,
    parameter logic [3:0] RSP_ID  = 4'h4,
    parameter logic [3:0] NONE_ID = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);

    logic [3:0]        srca_s;
    logic [3:0]        srcb_s;
    logic [3:0]        dste_s;
    logic [3:0]        dstm_s;
    logic [DATA_W-1:0] reg_r [0:Y86_NUM_REGS-1];

    y86_reg_ids #(
        .RSP_ID  (RSP_ID),
        .NONE_ID (NONE_ID)
    ) u_reg_ids (
        .icode (icode),
        .ra    (rA),
        .rb    (rB),
        .cnd   (cnd),
        .srca  (srca_s),
        .srcb  (srcb_s),
        .dste  (dste_s),
        .dstm  (dstm_s)
    );

    // Register array: async clear, commit E then M so M wins on a shared ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Y86_NUM_REGS; i++) begin
                reg_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en) begin
            if (dste_s != NONE_ID) begin
                reg_r[dste_s] <= valE;
            end
            if (dstm_s != NONE_ID) begin
                reg_r[dstm_s] <= valM;
            end
        end
    end

    // Read ports: current state only, NONE_ID reads as zero
    always_comb begin
        valA    = {DATA_W{1'b0}};
        valB    = {DATA_W{1'b0}};
        dbg_val = {DATA_W{1'b0}};
        if (srca_s != NONE_ID) begin
            valA = reg_r[srca_s];
        end else begin
            valA = {DATA_W{1'b0}};
        end
        if (srcb_s != NONE_ID) begin
            valB = reg_r[srcb_s];
        end else begin
            valB = {DATA_W{1'b0}};
        end
        if (dbg_sel != NONE_ID) begin
            dbg_val = reg_r[dbg_sel];
        end else begin
            dbg_val = {DATA_W{1'b0}};
        end
    end

    assign dstE = dste_s;
    assign dstM = dstm_s;

endmodule

// File: tb/tb_y86_regfile_decode.sv
// Scoreboard bench for y86_regfile_decode: stimulus queues expected values,
// a monitor process pops and compares each time a sample is presented.
module tb_y86_regfile_decode;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   icode;
    logic [3:0]   rA;
    logic [3:0]   rB;
    logic         cnd;
    logic [W-1:0] valE;
    logic [W-1:0] valM;
    logic         wb_en;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   dbg_sel;
    logic [W-1:0] dbg_val;

    y86_regfile_decode dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .wb_en   (wb_en),
        .valA    (valA),
        .valB    (valB),
        .dstE    (dstE),
        .dstM    (dstM),
        .dbg_sel (dbg_sel),
        .dbg_val (dbg_val)
    );

    // Slow clock so a batch of checks fits between edges
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Which DUT output an expectation refers to
    localparam int SEL_VALA = 0;
    localparam int SEL_VALB = 1;
    localparam int SEL_DBG  = 2;
    localparam int SEL_DSTE = 3;
    localparam int SEL_DSTM = 4;

    typedef struct {
        int           sel;
        logic [W-1:0] exp;
        string        name;
    } item_t;

    item_t q[$];
    event  sample_ev;
    int    n_pass  = 0;
    int    n_total = 0;

    // Monitor: compare every queued expectation against the presented outputs
    initial begin
        item_t        it;
        logic [W-1:0] act;
        forever begin
            @(sample_ev);
            while (q.size() != 0) begin
                it = q.pop_front();
                case (it.sel)
                    SEL_VALA: act = valA;
                    SEL_VALB: act = valB;
                    SEL_DBG:  act = dbg_val;
                    SEL_DSTE: act = {60'd0, dstE};
                    SEL_DSTM: act = {60'd0, dstM};
                    default:  act = 'x;
                endcase
                n_total++;
                if (act === it.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_out(input int sel, input logic [W-1:0] exp, input string name);
        item_t it;
        it.sel  = sel;
        it.exp  = exp;
        it.name = name;
        q.push_back(it);
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic expect_reg(input logic [3:0] id, input logic [W-1:0] exp, input string name);
        dbg_sel = id;
        expect_out(SEL_DBG, exp, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        icode   = 4'h1;
        rA      = 4'hF;
        rB      = 4'hF;
        cnd     = 1'b0;
        valE    = 64'd0;
        valM    = 64'd0;
        wb_en   = 1'b0;
        dbg_sel = 4'h0;

        // 1. Reset state, before any clock edge
        #2;
        for (int i = 0; i < 15; i++) begin
            expect_reg(4'(i), 64'd0, $sformatf("reset_reg%0d", i));
        end
        icode = 4'h6; rA = 4'h3; rB = 4'hF;
        expect_out(SEL_VALA, 64'd0, "reset_vala");
        @(negedge clk);
        rst_n = 1'b1;

        // 2. irmovq into %rdx, then read through opq srcA
        icode = 4'h3; rA = 4'hF; rB = 4'h2; valE = 64'h1234_5678_9ABC_DEF0; wb_en = 1'b1;
        expect_out(SEL_DSTE, 64'h2, "irmovq_dste");
        expect_out(SEL_DSTM, 64'hF, "irmovq_dstm");
        tick();
        wb_en = 1'b0; icode = 4'h6; rA = 4'h2; rB = 4'hF;
        expect_out(SEL_VALA, 64'h1234_5678_9ABC_DEF0, "irmovq_vala");
        expect_reg(4'h2, 64'h1234_5678_9ABC_DEF0, "irmovq_reg2");

        // 3. cmovXX gating: cnd=0 blocks, cnd=1 commits
        icode = 4'h2; rA = 4'h2; rB = 4'h5; cnd = 1'b0; valE = 64'd7; wb_en = 1'b1;
        expect_out(SEL_DSTE, 64'hF, "cmov_nc_dste");
        tick();
        expect_reg(4'h5, 64'd0, "cmov_nc_reg5");
        cnd = 1'b1;
        expect_out(SEL_DSTE, 64'h5, "cmov_c_dste");
        tick();
        expect_reg(4'h5, 64'd7, "cmov_c_reg5");
        cnd = 1'b0;

        // 4. popq %rsp: memory value wins over the stack-pointer update
        icode = 4'h3; rB = 4'h4; valE = 64'h100;
        tick();
        icode = 4'hB; rA = 4'h4; rB = 4'hF; valE = 64'h108; valM = 64'hDEAD;
        expect_out(SEL_VALA, 64'h100, "popq_vala");
        expect_out(SEL_VALB, 64'h100, "popq_valb");
        expect_out(SEL_DSTE, 64'h4, "popq_dste");
        expect_out(SEL_DSTM, 64'h4, "popq_dstm");
        tick();
        expect_reg(4'h4, 64'hDEAD, "popq_reg4");

        // pushq reads rA and %rsp, targets %rsp
        wb_en = 1'b0; icode = 4'hA; rA = 4'h2; rB = 4'hF;
        expect_out(SEL_VALA, 64'h1234_5678_9ABC_DEF0, "pushq_vala");
        expect_out(SEL_VALB, 64'hDEAD, "pushq_valb");
        expect_out(SEL_DSTE, 64'h4, "pushq_dste");

        // 5. wb_en=0 blocks the commit
        icode = 4'h3; rB = 4'h1; valE = 64'd99; wb_en = 1'b0;
        tick();
        expect_reg(4'h1, 64'd0, "wben0_reg1");

        // 6. No forwarding, NONE reads zero
        icode = 4'h3; rB = 4'h3; valE = 64'hAA; wb_en = 1'b1;
        tick();
        icode = 4'h6; rA = 4'hF; rB = 4'h3; valE = 64'hBB;
        expect_out(SEL_VALA, 64'd0, "none_vala");
        expect_out(SEL_VALB, 64'hAA, "nofwd_old_valb");
        expect_out(SEL_DSTE, 64'h3, "opq_dste");
        tick();
        wb_en = 1'b0;
        expect_out(SEL_VALB, 64'hBB, "nofwd_new_valb");

        // Undefined icode decodes to all-NONE even with live registers
        icode = 4'hC; rA = 4'h2; rB = 4'h3;
        expect_out(SEL_DSTE, 64'hF, "undef_dste");
        expect_out(SEL_DSTM, 64'hF, "undef_dstm");
        expect_out(SEL_VALA, 64'd0, "undef_vala");
        expect_out(SEL_VALB, 64'd0, "undef_valb");

        // Mid-cycle reset clears everything at once and drops the pending write
        icode = 4'h3; rB = 4'h2; valE = 64'h5; wb_en = 1'b1;
        #10;
        rst_n = 1'b0;
        expect_reg(4'h2, 64'd0, "midrst_reg2");
        expect_reg(4'h3, 64'd0, "midrst_reg3");
        expect_reg(4'h4, 64'd0, "midrst_reg4");
        expect_reg(4'h5, 64'd0, "midrst_reg5");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        wb_en = 1'b0;
        expect_reg(4'h2, 64'd0, "midrst_nowrite_reg2");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            #1;
        end
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/y86_regfile_decode.md
Name: y86_regfile_decode

Overview:
- Decode/write-back stage of the Y86-64 single-cycle CPU.
- Derives register IDs srcA, srcB, dstE and dstM from icode, rA, rB and Cnd.
- Holds the 15 architectural 64-bit registers and supplies valA/valB combinationally to the ALU operand muxes and the memory stage.
- Commits valE/valM on the rising clock edge that ends the instruction.

Parameters:
- DATA_W, 64, register and data width.
- RSP_ID, 4'h4, register ID of %rsp used by push/pop/call/ret.
- NONE_ID, 4'hF, "no register" ID.

Ports:
- clk  in  1  system clock, all writes on rising edge
- rst_n  in  1  asynchronous active-low reset
- icode  in  4  instruction code from fetch
- rA  in  4  rA field from fetch
- rB  in  4  rB field from fetch
- cnd  in  1  condition result from the condition-code/ALU block (cmovXX gating)
- valE  in  DATA_W  ALU result to write back
- valM  in  DATA_W  memory read data to write back
- wb_en  in  1  write-back enable; low when Stat != AOK (halt/exception) to block commits
- valA  out  DATA_W  read data for srcA
- valB  out  DATA_W  read data for srcB
- dstE  out  4  decoded E destination, exported for trace
- dstM  out  4  decoded M destination, exported for trace
- dbg_sel  in  4  debug read register ID
- dbg_val  out  DATA_W  debug read data

Behaviour:
- Reset: rst_n low asynchronously clears all 15 registers to 0, independent of clk. Consequently valA, valB and dbg_val read 0 while in reset and until the first write. Reset asserted mid-cycle discards any pending write.
- srcA: rA for icode 2,4,6,A; RSP_ID for 9,B; else NONE_ID.
- srcB: rB for 4,5,6; RSP_ID for 8,9,A,B; else NONE_ID.
- dstE:
  - rB for icode 2 only when cnd=1, else NONE_ID.
  - rB for 3,6.
  - RSP_ID for 8,9,A,B.
  - Else NONE_ID.
- dstM: rA for 5,B; else NONE_ID.
- Undefined icodes (C-F) decode all four IDs to NONE_ID.
- Reads:
  - Purely combinational from current register state; zero latency.
  - ID NONE_ID returns 0.
  - No write-to-read forwarding: a value written at edge N is visible on valA/valB only after edge N.
- Writes, on rising clk when rst_n=1 and wb_en=1:
  - reg[dstE] <= valE if dstE != NONE_ID.
  - reg[dstM] <= valM if dstM != NONE_ID.
- Simultaneous dstE == dstM (e.g. popq %rsp): valM wins, so the register holds the memory value.
- wb_en=0: no register changes; decode outputs still valid.
- Arithmetic: none; the stage only routes 64-bit values, with no truncation or extension.

Decomposition:
- Shared package (y86_pkg):
  - icode constants (HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B).
  - Register ID constants (RSP=4, NONE=F).
  - DATA_W.
- Natural sub-module: y86_reg_ids, a combinational decoder producing srcA/srcB/dstE/dstM from icode/rA/rB/cnd.
- The top level holds the register array, read muxes and write logic.

Test Plan:
1. Reset: drive rst_n=0 with no clk edge -> dbg_val=0 for all IDs 0-E; valA=0 for icode=6, rA=3.
2. irmovq: icode=3, rB=2, valE=0x1234_5678_9ABC_DEF0, wb_en=1, one edge -> reg2=0x1234_5678_9ABC_DEF0. Then icode=6, rA=2 -> valA equals that value.
3. cmovXX gating:
   - icode=2, rB=5, cnd=0, valE=7 -> dstE=F, reg5 unchanged.
   - Same stimulus with cnd=1 -> reg5=7.
4. popq %rsp: reg4=0x100; icode=B, rA=4, valE=0x108, valM=0xDEAD, one edge -> reg4=0xDEAD (M priority). Also srcA=srcB=4 before the edge, so valA=valB=0x100.
5. wb_en=0: icode=3, rB=1, valE=99, wb_en=0, edge -> reg1 unchanged. Then rst_n pulsed low mid-cycle -> all registers 0 immediately.
6. No forwarding / NONE read: icode=6, rA=F -> valA=0. During a write of reg3, valB (rB=3) shows the old value until the edge, then the new value.
